// File: rtl/muldiv_ctrl_pkg.sv
// Shared types, funct codes and FSM encodings for the multiply/divide sequencer.
// Optional macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier in muldiv_ctrl.
package muldiv_ctrl_pkg;

  typedef logic [5:0]  u6;
  typedef logic [31:0] u32;
  typedef logic [63:0] u64;

  localparam u6 F6_MFHI  = 6'b010000;
  localparam u6 F6_MTHI  = 6'b010001;
  localparam u6 F6_MFLO  = 6'b010010;
  localparam u6 F6_MTLO  = 6'b010011;
  localparam u6 F6_MULT  = 6'b011000;
  localparam u6 F6_MULTU = 6'b011001;
  localparam u6 F6_DIV   = 6'b011010;
  localparam u6 F6_DIVU  = 6'b011011;

  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t ST_IDLE = 2'd0;
  localparam muldiv_state_t ST_MUL  = 2'd1;
  localparam muldiv_state_t ST_DIV  = 2'd2;
  localparam muldiv_state_t ST_FIX  = 2'd3;

  // Magnitude of a two's-complement value when treated as signed.
  function automatic u32 mag32(input u32 v, input logic is_signed);
    return (is_signed && v[31]) ? u32'(-v) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Accumulator layout: mul {partial product, multiplier}; div {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_ctrl_pkg::*;
(
  input  logic mode_div,
  input  u64   acc,
  input  u32   operand,
  output u64   acc_next,
  output logic q_bit
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [32:0] diff;

  always_comb begin
    sum      = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? operand : 32'd0)};
    rem_sh   = acc[63:31];
    diff     = rem_sh - {1'b0, operand};
    q_bit    = 1'b0;
    acc_next = '0;
    if (mode_div) begin
      // rem_sh < 2*operand, so a clear borrow bit means the subtract fits in 32 bits
      q_bit    = ~diff[32];
      acc_next = {(q_bit ? diff[31:0] : rem_sh[31:0]), acc[30:0], q_bit};
    end else begin
      acc_next = {sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO.
// Define MULDIV_FAST_MUL_EN to replace the 32-step multiply with a single-cycle product.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_valid,
  output logic req_ready,
  input  u6    funct,
  input  u32   src_a,
  input  u32   src_b,
  input  logic flush,
  output logic busy,
  output logic done,
  output u32   hi,
  output u32   lo
);

  muldiv_state_t state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  u64            acc_q, acc_d;
  u32            opnd_q, opnd_d;
  logic          negq_q, negq_d, negr_q, negr_d;
  logic          is_div_q, is_div_d, dz_q, dz_d, done_q, done_d;
  u32            hi_q, hi_d, lo_q, lo_d;
`ifdef MULDIV_FAST_MUL_EN
  logic          sgn_q, sgn_d;
  u64            ext_a, ext_b, mul_res;
`else
  u64            mul_res;
`endif

  u64   step_acc;
  logic step_q;
  u32   quo, rem;
  logic is_mul_f, is_div_f, is_sgn, accept;

  assign req_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

  muldiv_step u_step (
    .mode_div (state_q == ST_DIV),
    .acc      (acc_q),
    .operand  (opnd_q),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  always_comb begin
    is_mul_f = (funct == F6_MULT) || (funct == F6_MULTU);
    is_div_f = (funct == F6_DIV)  || (funct == F6_DIVU);
    is_sgn   = (funct == F6_MULT) || (funct == F6_DIV);
    accept   = req_valid && req_ready && !flush &&
               (is_mul_f || is_div_f || funct == F6_MTHI || funct == F6_MTLO);

`ifdef MULDIV_FAST_MUL_EN
    // Raw operands sit in acc; sign- or zero-extend and keep the low 64 bits.
    ext_a   = sgn_q ? {{32{acc_q[63]}}, acc_q[63:32]} : {32'd0, acc_q[63:32]};
    ext_b   = sgn_q ? {{32{acc_q[31]}}, acc_q[31:0]}  : {32'd0, acc_q[31:0]};
    mul_res = ext_a * ext_b;
    sgn_d   = sgn_q;
`else
    mul_res = negq_q ? u64'(-acc_q) : acc_q;
`endif
    quo = negq_q ? u32'(-acc_q[31:0])  : acc_q[31:0];
    rem = negr_q ? u32'(-acc_q[63:32]) : acc_q[63:32];

    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    is_div_d = is_div_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d  = '0;
          acc_d  = {32'd0, mag32(src_a, is_sgn)};
          opnd_d = mag32(src_b, is_sgn);
          negq_d = is_sgn && (src_a[31] ^ src_b[31]);
          negr_d = is_sgn && src_a[31];
          if (funct == F6_MTHI) begin
            hi_d = src_a;
          end else if (funct == F6_MTLO) begin
            lo_d = src_a;
          end else if (is_mul_f) begin
            is_div_d = 1'b0;
            dz_d     = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            acc_d   = {src_a, src_b};
            sgn_d   = is_sgn;
            state_d = ST_FIX;
`else
            state_d = ST_MUL;
`endif
          end else begin
            is_div_d = 1'b1;
            dz_d     = (src_b == 32'd0);
            state_d  = (src_b == 32'd0) ? ST_FIX : ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        acc_d = (state_q == ST_DIV) ? {step_acc[63:1], step_q} : step_acc;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      default: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (!dz_q) begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          {hi_d, lo_d} = mul_res;
        end
      end
    endcase

    // A flush abandons the op without touching HI/LO.
    if (flush && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MULDIV_FAST_MUL_EN
      sgn_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MULDIV_FAST_MUL_EN
      sgn_q    <= sgn_d;
`endif
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed plan cases plus random ops vs an arithmetic model.
// Expected multiply latency follows MULDIV_FAST_MUL_EN.
module tb_muldiv_ctrl;

  localparam logic [5:0] MTHI  = 6'b010001;
  localparam logic [5:0] MTLO  = 6'b010011;
  localparam logic [5:0] MULT  = 6'b011000;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] DIV   = 6'b011010;
  localparam logic [5:0] DIVU  = 6'b011011;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        reset, req_valid, flush;
  logic        req_ready, busy, done;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b, hi, lo;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .funct(funct), .src_a(src_a), .src_b(src_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Architectural result of one op; lat = cycles from accept to done (0 = no done).
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output int lat);
    longint sa, sb;
    logic [63:0] p;
    eh = m_hi; el = m_lo; lat = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (f)
      MTHI:  eh = a;
      MTLO:  el = a;
      MULTU: begin p = {32'd0, a} * {32'd0, b}; {eh, el} = p; lat = MUL_LAT; end
      MULT:  begin p = 64'(sa * sb); {eh, el} = p; lat = MUL_LAT; end
      DIVU:  begin
        lat = (b == 0) ? 2 : 34;
        if (b != 0) begin el = a / b; eh = a % b; end
      end
      default: begin
        lat = (b == 0) ? 2 : 34;
        if (b != 0) begin el = 32'(sa / sb); eh = 32'(sa % sb); end
      end
    endcase
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 1; busy_cnt = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eh, el;
    int exp_lat, lat, bc;
    model(f, a, b, eh, el, exp_lat);
    check({tag, "_ready"}, req_ready, 1);
    req_valid = 1; funct = f; src_a = a; src_b = b;
    tick();
    req_valid = 0;
    if (exp_lat == 0) begin
      check({tag, "_busy"}, busy, 0);
    end else begin
      wait_done(lat, bc);
      check({tag, "_lat"}, lat, exp_lat);
      check({tag, "_busycyc"}, bc, exp_lat - 1);
      check({tag, "_rdy_at_done"}, req_ready, 1);
    end
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    m_hi = eh; m_lo = el;
    $display("op %s funct=%b a=%h b=%h -> hi=%h lo=%h", tag, f, a, b, hi, lo);
    if (exp_lat != 0) begin
      tick();
      check({tag, "_done_pulse"}, done, 0);
    end
  endtask

  initial begin
    int lat, bc, dcnt;
    logic [5:0] fset [6];
    logic [5:0] f;
    logic [31:0] a, b;
    fset = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO};
    reset = 1; req_valid = 0; flush = 0; funct = 0; src_a = 0; src_b = 0;
    tick(); tick();
    reset = 0;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", req_ready, 1);

    // Directed plan cases
    run_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check("multu_max_hi_const", hi, 32'hFFFFFFFE);
    check("multu_max_lo_const", lo, 32'h00000001);
    run_op("mult_neg", MULT, 32'hFFFFFFFD, 32'h00000005);
    check("mult_neg_lo_const", lo, 32'hFFFFFFF1);
    run_op("div_neg", DIV, 32'hFFFFFFF9, 32'h00000002);
    check("div_neg_lo_const", lo, 32'hFFFFFFFD);
    check("div_neg_hi_const", hi, 32'hFFFFFFFF);
    run_op("divu_7_2", DIVU, 32'd7, 32'd2);
    check("divu_lo_const", lo, 32'd3);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF);
    check("div_ovf_lo_const", lo, 32'h80000000);
    check("div_ovf_hi_const", hi, 32'd0);

    // MTHI then MTLO back-to-back
    req_valid = 1; funct = MTHI; src_a = 32'h1234;
    tick();
    check("mthi_busy", busy, 0);
    funct = MTLO; src_a = 32'h5678;
    tick();
    req_valid = 0;
    check("mtlo_busy", busy, 0);
    check("mt_hi", hi, 32'h1234);
    check("mt_lo", lo, 32'h5678);
    m_hi = 32'h1234; m_lo = 32'h5678;
    run_op("divu_by0", DIVU, 32'd99, 32'd0);

    // Flush blocks accept in IDLE
    req_valid = 1; funct = MTHI; src_a = 32'hDEAD; flush = 1;
    tick();
    req_valid = 0; flush = 0;
    check("flush_idle_hi", hi, m_hi);

    // Flush 10 cycles into a DIV
    req_valid = 1; funct = DIV; src_a = 32'd1000; src_b = 32'd3;
    tick();
    req_valid = 0;
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    check("flush_ready", req_ready, 1);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);
    dcnt = 0;
    repeat (40) begin
      if (done) dcnt++;
      tick();
    end
    check("flush_no_done", dcnt, 0);
    $display("flush mid-DIV -> hi=%h lo=%h", hi, lo);

    // Reset mid-MUL
    req_valid = 1; funct = MULT; src_a = 32'd12345; src_b = 32'd678;
    tick();
    req_valid = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    check("rstmid_hi", hi, 0);
    check("rstmid_lo", lo, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_done", done, 0);
    m_hi = 0; m_lo = 0;
    $display("reset mid-MUL -> hi=%h lo=%h", hi, lo);

    // req_valid held while busy: next op accepted only in the done cycle
    req_valid = 1; funct = DIVU; src_a = 32'd100; src_b = 32'd7;
    tick();
    funct = MULTU; src_a = 32'd3; src_b = 32'd5;
    lat = 1;
    while (!req_ready && lat < 200) begin tick(); lat++; end
    check("held_lat", lat, 34);
    check("held_done", done, 1);
    check("held_lo", lo, 32'd14);
    check("held_hi", hi, 32'd2);
    tick();
    req_valid = 0;
    check("held_accepted_busy", busy, (MUL_LAT > 2) ? 1 : 1);
    wait_done(lat, bc);
    check("held_2nd_lat", lat, MUL_LAT);
    check("held_2nd_lo", lo, 32'd15);
    check("held_2nd_hi", hi, 32'd0);
    m_hi = 0; m_lo = 15;
    $display("held op -> hi=%h lo=%h", hi, lo);
    tick();

    // Random ops against the model
    for (int i = 0; i < 24; i++) begin
      f = fset[$urandom_range(0, 5)];
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      run_op($sformatf("rnd%0d", i), f, a, b);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
